// File: rtl/clk_en_pkg.sv
// clk_en_pkg
// Shared constants for the clock-enable generator and the timing blocks that
// instantiate it (PSG cores, pixel/line timers).
//   - CE_MODE_INT / CE_MODE_FRAC : channel mode encoding
//   - CE_DEFAULT_*               : default channel count, width and divisor
//   - ch_sel_width()             : channel-select width for a channel count
package clk_en_pkg;

    localparam logic CE_MODE_INT  = 1'b0;
    localparam logic CE_MODE_FRAC = 1'b1;

    localparam int CE_DEFAULT_CHANNELS = 4;
    localparam int CE_DEFAULT_WIDTH    = 16;
    localparam int CE_DEFAULT_DIV      = 31;

    // A single channel still needs a one-bit select port.
    function automatic int ch_sel_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/clk_en_channel.sv
// clk_en_channel
// One clock-enable channel: integer down-counter divider (period div+1) or
// fractional phase accumulator (average rate inc/2^WIDTH).
// Ports:
//   clk, rst_n      : system clock, async active-low reset
//   en              : run enable; when low the phase state holds, ce is 0
//   sync            : restart phase (load cnt from shadow, clear acc)
//   wr, wr_mode,
//   wr_val          : configuration write already decoded for this channel
//   ce              : registered one-cycle enable strobe
//   tog             : registered square wave, inverts on every strobe
module clk_en_channel
    import clk_en_pkg::*;
#(
    parameter int WIDTH       = CE_DEFAULT_WIDTH,
    parameter int DEFAULT_DIV = CE_DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic             wr_mode,
    input  logic [WIDTH-1:0] wr_val,
    output logic             ce,
    output logic             tog
);

    logic             mode_q,    mode_d;
    logic [WIDTH-1:0] shadow_q,  shadow_d;
    logic [WIDTH-1:0] div_act_q, div_act_d;
    logic [WIDTH-1:0] cnt_q,     cnt_d;
    logic [WIDTH-1:0] acc_q,     acc_d;
    logic             ce_q,      ce_d;
    logic             tog_q,     tog_d;

    logic [WIDTH:0]   sum_s;
    logic             mode_change_s;

    // Next-state for configuration, counter, accumulator and outputs.
    always_comb begin
        mode_d    = mode_q;
        shadow_d  = shadow_q;
        div_act_d = div_act_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        ce_d      = 1'b0;

        // Carry out of this sum is the only fractional strobe source.
        sum_s         = {1'b0, acc_q} + {1'b0, shadow_q};
        mode_change_s = wr && (wr_mode != mode_q);

        if (wr) begin
            shadow_d = wr_val;
            mode_d   = wr_mode;
        end else begin
            shadow_d = shadow_q;
            mode_d   = mode_q;
        end

        if (sync) begin
            // Uses shadow_d so a simultaneous write feeds the sync load.
            cnt_d     = shadow_d;
            div_act_d = shadow_d;
            acc_d     = {WIDTH{1'b0}};
        end else if (mode_change_s) begin
            cnt_d = {WIDTH{1'b0}};
            acc_d = {WIDTH{1'b0}};
        end else if (en) begin
            // Reload reads shadow_q: a write on this edge only counts from the next one.
            case (mode_q)
                CE_MODE_INT: begin
                    if (cnt_q == {WIDTH{1'b0}}) begin
                        cnt_d     = shadow_q;
                        div_act_d = shadow_q;
                        ce_d      = 1'b1;
                    end else begin
                        cnt_d = cnt_q - {{(WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                CE_MODE_FRAC: begin
                    acc_d = sum_s[WIDTH-1:0];
                    ce_d  = sum_s[WIDTH];
                end
                default: begin
                    cnt_d = {WIDTH{1'b0}};
                    acc_d = {WIDTH{1'b0}};
                end
            endcase
        end else begin
            ce_d = 1'b0;
        end

        if (ce_d) begin
            tog_d = ~tog_q;
        end else begin
            tog_d = tog_q;
        end
    end

    // Channel state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= CE_MODE_INT;
            shadow_q  <= WIDTH'(DEFAULT_DIV);
            div_act_q <= WIDTH'(DEFAULT_DIV);
            cnt_q     <= {WIDTH{1'b0}};
            acc_q     <= {WIDTH{1'b0}};
            ce_q      <= 1'b0;
            tog_q     <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            shadow_q  <= shadow_d;
            div_act_q <= div_act_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            ce_q      <= ce_d;
            tog_q     <= tog_d;
        end
    end

    assign ce  = ce_q;
    assign tog = tog_q;

endmodule

// File: rtl/clk_en_gen.sv
// clk_en_gen
// Multi-channel clock-enable generator. Decodes configuration writes to one
// channel, fans sync out to every channel, and instantiates CHANNELS
// clk_en_channel blocks.
// Ports:
//   clk, rst_n            : system clock, async active-low reset
//   en[CHANNELS]          : per-channel run enable
//   sync                  : restart phase of all channels
//   cfg_we, cfg_ch,
//   cfg_mode, cfg_val     : configuration write port
//   ce[CHANNELS]          : registered strobes
//   tog[CHANNELS]         : registered toggles
module clk_en_gen
    import clk_en_pkg::*;
#(
    parameter int CHANNELS    = CE_DEFAULT_CHANNELS,
    parameter int WIDTH       = CE_DEFAULT_WIDTH,
    parameter int DEFAULT_DIV = CE_DEFAULT_DIV,
    parameter int CH_W        = ch_sel_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic                cfg_mode,
    input  logic [WIDTH-1:0]    cfg_val,
    output logic [CHANNELS-1:0] ce,
    output logic [CHANNELS-1:0] tog
);

    logic [CHANNELS-1:0] wr_sel_s;

    // Write decode: a select at or beyond CHANNELS matches no instance and is dropped.
    always_comb begin
        wr_sel_s = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_we && (32'(cfg_ch) == 32'(i))) begin
                wr_sel_s[i] = 1'b1;
            end else begin
                wr_sel_s[i] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        clk_en_channel #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en[g]),
            .sync    (sync),
            .wr      (wr_sel_s[g]),
            .wr_mode (cfg_mode),
            .wr_val  (cfg_val),
            .ce      (ce[g]),
            .tog     (tog[g])
        );
    end

endmodule

// File: tb/tb_clk_en_gen.sv
// tb_clk_en_gen
// Directed bench for clk_en_gen (4 channels) plus a 3-channel instance that
// receives a write to a non-existent channel.
module tb_clk_en_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  en = 4'hF;
    logic        sync = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = 2'd0;
    logic        cfg_mode = 1'b0;
    logic [15:0] cfg_val = 16'h0000;
    logic [3:0]  ce;
    logic [3:0]  tog;

    logic [2:0]  en2 = 3'b111;
    logic        sync2 = 1'b0;
    logic        cfg_we2 = 1'b0;
    logic [1:0]  cfg_ch2 = 2'd0;
    logic        cfg_mode2 = 1'b0;
    logic [15:0] cfg_val2 = 16'h0000;
    logic [2:0]  ce2;
    logic [2:0]  tog2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nstr;

    clk_en_gen #(.CHANNELS(4), .WIDTH(16), .DEFAULT_DIV(31)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_val(cfg_val),
        .ce(ce), .tog(tog)
    );

    clk_en_gen #(.CHANNELS(3), .WIDTH(16), .DEFAULT_DIV(31)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en2), .sync(sync2), .cfg_we(cfg_we2),
        .cfg_ch(cfg_ch2), .cfg_mode(cfg_mode2), .cfg_val(cfg_val2),
        .ce(ce2), .tog(tog2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Advance to 1 time unit after rising edge n (edges counted from reset release).
    task automatic to_edge(input int n);
        while (cyc < n) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic write_at(input int k, input logic [1:0] ch, input logic mode, input logic [15:0] val);
        to_edge(k - 1);
        cfg_we = 1'b1; cfg_ch = ch; cfg_mode = mode; cfg_val = val;
        to_edge(k);
        cfg_we = 1'b0;
    endtask

    initial begin
        // ---------------- reset state and default /32 ----------------
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_ce", 32'(ce), 32'h0);
        chk("reset_tog", 32'(tog), 32'h0);
        do_reset();
        to_edge(1);
        chk("first_ce", 32'(ce), 32'hF);
        chk("first_tog", 32'(tog), 32'hF);
        chk("dut2_first_ce", 32'(ce2), 32'h7);
        to_edge(2);
        chk("ce_drop", 32'(ce), 32'h0);
        // ch1 div=2 at edge 10; dut2 write to channel 3 (absent) at edge 10
        to_edge(9);
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_mode = 1'b0; cfg_val = 16'd2;
        cfg_we2 = 1'b1; cfg_ch2 = 2'd3; cfg_mode2 = 1'b1; cfg_val2 = 16'd0;
        to_edge(10);
        cfg_we = 1'b0; cfg_we2 = 1'b0;
        to_edge(32);
        chk("ce_before_33", 32'(ce), 32'h0);
        chk("tog0_half1", 32'(tog[0]), 32'h1);
        to_edge(33);
        chk("ce_33", 32'(ce), 32'hF);
        chk("tog_33", 32'(tog), 32'h0);
        chk("dut2_ce_33", 32'(ce2), 32'h7);
        to_edge(34);
        chk("ce_34", 32'(ce), 32'h0);
        chk("dut2_ce_34", 32'(ce2), 32'h0);
        to_edge(36);
        chk("ch1_div2_36", 32'(ce), 32'h2);
        to_edge(37);
        chk("ch1_div2_37", 32'(ce), 32'h0);
        to_edge(39);
        chk("ch1_div2_39", 32'(ce), 32'h2);
        to_edge(42);
        chk("ch1_div2_42", 32'(ce), 32'h2);
        write_at(43, 2'd1, 1'b0, 16'd0);
        to_edge(44);
        chk("ch1_div0_44", 32'(ce), 32'h0);
        for (int e = 45; e <= 50; e++) begin
            to_edge(e);
            chk("ch1_div0_cont", 32'(ce), 32'h2);
        end
        to_edge(64);
        chk("tog0_half2", 32'(tog[0]), 32'h0);
        to_edge(65);
        chk("ce_65", 32'(ce), 32'hF);
        chk("tog0_65", 32'(tog[0]), 32'h1);
        chk("dut2_ce_65", 32'(ce2), 32'h7);

        // ---------------- fractional channel 2 ----------------
        do_reset();
        write_at(2, 2'd2, 1'b1, 16'h4000);
        to_edge(5);
        chk("frac4_5", 32'(ce[2]), 32'h0);
        to_edge(6);
        chk("frac4_6", 32'(ce[2]), 32'h1);
        to_edge(7);
        chk("frac4_7", 32'(ce[2]), 32'h0);
        to_edge(10);
        chk("frac4_10", 32'(ce[2]), 32'h1);
        to_edge(14);
        chk("frac4_14", 32'(ce[2]), 32'h1);
        write_at(15, 2'd2, 1'b1, 16'h6000);
        to_edge(19);
        sync = 1'b1;
        to_edge(20);
        sync = 1'b0;
        chk("sync_ce_zero", 32'(ce), 32'h0);
        nstr = 0;
        for (int e = 21; e <= 84; e++) begin
            to_edge(e);
            if (ce[2]) nstr++;
            if (e == 23) chk("frac6_23", 32'(ce[2]), 32'h1);
        end
        chk("frac6_count64", 32'(nstr), 32'd24);

        // ---------------- sync alignment, div=9 ----------------
        do_reset();
        write_at(3, 2'd0, 1'b0, 16'd9);
        write_at(4, 2'd2, 1'b0, 16'd9);
        write_at(5, 2'd1, 1'b1, 16'd9);
        write_at(6, 2'd3, 1'b1, 16'd9);
        write_at(7, 2'd1, 1'b0, 16'd9);
        write_at(8, 2'd3, 1'b0, 16'd9);
        to_edge(93);
        chk("phase_93", 32'(ce), 32'h5);
        to_edge(98);
        chk("phase_98", 32'(ce), 32'h2);
        to_edge(99);
        chk("phase_99", 32'(ce), 32'h8);
        sync = 1'b1;
        to_edge(100);
        sync = 1'b0;
        chk("sync_100", 32'(ce), 32'h0);
        to_edge(103);
        chk("sync_103", 32'(ce), 32'h0);
        to_edge(109);
        chk("sync_109", 32'(ce), 32'h0);
        to_edge(110);
        chk("aligned_110", 32'(ce), 32'hF);
        to_edge(111);
        chk("aligned_111", 32'(ce), 32'h0);
        to_edge(120);
        chk("aligned_120", 32'(ce), 32'hF);
        to_edge(130);
        chk("aligned_130", 32'(ce), 32'hF);

        // ---------------- ch3 enable gap of 5 cycles ----------------
        to_edge(132);
        en = 4'b0111;
        to_edge(135);
        chk("gap_135", 32'(ce), 32'h0);
        to_edge(137);
        en = 4'hF;
        to_edge(140);
        chk("gap_140", 32'(ce), 32'h7);
        to_edge(145);
        chk("gap_145", 32'(ce), 32'h8);
        to_edge(150);
        chk("gap_150", 32'(ce), 32'h7);
        to_edge(155);
        chk("gap_155", 32'(ce), 32'h8);

        // ---------------- async reset between edges ----------------
        to_edge(160);
        chk("pre_rst_ce", 32'(ce), 32'h7);
        chk("pre_rst_tog", 32'(tog), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ce", 32'(ce), 32'h0);
        chk("async_rst_tog", 32'(tog), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        to_edge(1);
        chk("rerst_first_ce", 32'(ce), 32'hF);
        to_edge(2);
        chk("rerst_ce_2", 32'(ce), 32'h0);
        to_edge(32);
        chk("rerst_ce_32", 32'(ce), 32'h0);
        to_edge(33);
        chk("rerst_ce_33", 32'(ce), 32'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
